// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 blocks x 4 bytes, 8-bit address.
// Misses stall the cpu through BUSYWAIT while a dirty victim is written back and the block is fetched.
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic [1:0]  DEBUG_STATE
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] data_mem [8];
    logic [2:0]  tag_mem  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [2:0] addr_tag;
    logic [2:0] addr_index;
    logic [1:0] addr_offset;
    logic       hit;
    logic       request;

    assign addr_tag    = ADDRESS[7:5];
    assign addr_index  = ADDRESS[4:2];
    assign addr_offset = ADDRESS[1:0];
    assign request     = READ | WRITE;
    assign hit         = valid[addr_index] && (tag_mem[addr_index] == addr_tag);

    assign DEBUG_STATE = state;
    assign MEM_READ    = mem_read_q;
    assign MEM_WRITE   = mem_write_q;

    always_comb begin
        BUSYWAIT      = 1'b1;
        READDATA      = 8'h00;
        MEM_ADDRESS   = 6'h00;
        MEM_WRITEDATA = 32'h0;
        if (hit) begin
            READDATA = data_mem[addr_index][{addr_offset, 3'b000} +: 8];
        end
        case (state)
            IDLE: begin
                BUSYWAIT = request & ~hit;
            end
            WRITEBACK: begin
                // The victim goes back under its own stored tag, not the requested one.
                MEM_ADDRESS   = {tag_mem[addr_index], addr_index};
                MEM_WRITEDATA = data_mem[addr_index];
            end
            FETCH: begin
                MEM_ADDRESS = ADDRESS[7:2];
            end
            default: begin
                BUSYWAIT = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            valid       <= 8'h00;
            dirty       <= 8'h00;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && !hit) begin
                        if (valid[addr_index] && dirty[addr_index]) begin
                            state       <= WRITEBACK;
                            mem_write_q <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            mem_read_q <= 1'b1;
                        end
                    end else if (WRITE && hit) begin
                        data_mem[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
                        dirty[addr_index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        dirty[addr_index] <= 1'b0;
                        state             <= FETCH;
                        mem_write_q       <= 1'b0;
                        mem_read_q        <= 1'b1;
                    end
                end
                FETCH: begin
                    // A pending store is applied on the following IDLE cycle as an ordinary hit.
                    if (!MEM_BUSYWAIT) begin
                        data_mem[addr_index] <= MEM_READDATA;
                        tag_mem[addr_index]  <= addr_tag;
                        valid[addr_index]    <= 1'b1;
                        dirty[addr_index]    <= 1'b0;
                        state                <= IDLE;
                        mem_read_q           <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: behavioural block memory with settable latency, a byte-level
// reference memory plus a residency model, directed vectors, corner sequences and random traffic.
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
    logic [1:0]  DEBUG_STATE;

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .DEBUG_STATE(DEBUG_STATE)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- block memory and reference model ----------------
    logic [31:0] mem_words [64];
    logic [7:0]  ref_bytes [256];
    int          resident [8];
    bit          modified [8];
    int          lat = 3;
    int          mem_cnt = 0;

    function automatic logic [31:0] ref_block(input int blk);
        return {ref_bytes[blk*4+3], ref_bytes[blk*4+2], ref_bytes[blk*4+1], ref_bytes[blk*4]};
    endfunction

    // After reset the cache forgets everything: memory becomes the only copy.
    task automatic model_reset();
        for (int b = 0; b < 64; b++)
            for (int k = 0; k < 4; k++)
                ref_bytes[b*4+k] = mem_words[b][k*8 +: 8];
        for (int s = 0; s < 8; s++) begin
            resident[s] = -1;
            modified[s] = 1'b0;
        end
    endtask

    // Expected stall cycles for one access, then update residency.
    function automatic int model_access(input bit wr, input logic [7:0] addr);
        int blk = int'(addr) / 4;
        int slot = blk % 8;
        int st = 0;
        if (resident[slot] != blk) begin
            st = modified[slot] ? (2*lat + 3) : (lat + 2);
            resident[slot] = blk;
            modified[slot] = 1'b0;
        end
        if (wr) modified[slot] = 1'b1;
        return st;
    endfunction

    always @(negedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            check("mem_rd_wr_exclusive", {31'b0, MEM_READ & MEM_WRITE}, 32'd0);
            mem_cnt++;
            if (mem_cnt > lat) begin
                MEM_BUSYWAIT = 1'b0;
                if (MEM_READ) begin
                    MEM_READDATA = mem_words[MEM_ADDRESS];
                end else begin
                    check("writeback_data", MEM_WRITEDATA, ref_block(int'(MEM_ADDRESS)));
                    mem_words[MEM_ADDRESS] = MEM_WRITEDATA;
                end
                mem_cnt = 0;
            end else begin
                MEM_BUSYWAIT = 1'b1;
            end
        end else begin
            mem_cnt = 0;
            MEM_BUSYWAIT = 1'b1;
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 after the access has retired.
    task automatic do_access(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                             output int stall, output logic [7:0] rd);
        READ = ~wr; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
        stall = 0;
        #1;
        while (BUSYWAIT !== 1'b0 && stall < 300) begin
            @(posedge CLK); #1;
            stall++;
        end
        rd = READDATA;
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    // Runs an access through the model and DUT, checking stall count and load data.
    task automatic run_checked(input string name, input bit wr, input logic [7:0] addr,
                               input logic [7:0] wd);
        int exp_st;
        int st;
        logic [7:0] rd;
        exp_st = model_access(wr, addr);
        do_access(wr, addr, wd, st, rd);
        check({name, "_stall"}, st, exp_st);
        if (!wr) check({name, "_rdata"}, {24'b0, rd}, {24'b0, ref_bytes[addr]});
        if (wr) ref_bytes[addr] = wd;
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         exp_stall;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int st;
        logic [7:0] rd;
        int exp_st;

        vecs[0] = '{1'b0, 8'h05, 8'h00, 5, 8'hBB};
        vecs[1] = '{1'b1, 8'h06, 8'h5A, 0, 8'h00};
        vecs[2] = '{1'b0, 8'h06, 8'h00, 0, 8'h5A};
        vecs[3] = '{1'b0, 8'h26, 8'h00, 9, 8'h33};
        vecs[4] = '{1'b1, 8'h40, 8'h77, 5, 8'h00};
        vecs[5] = '{1'b0, 8'h40, 8'h00, 0, 8'h77};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 9, 8'h01};
        vecs[7] = '{1'b0, 8'h27, 8'h00, 0, 8'h44};

        for (int b = 0; b < 64; b++) mem_words[b] = $urandom;
        mem_words[0] = 32'h0403_0201;
        mem_words[1] = 32'hDDCC_BBAA;
        mem_words[9] = 32'h4433_2211;
        MEM_READDATA = 32'h0;
        MEM_BUSYWAIT = 1'b1;

        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        check("reset_busywait", {31'b0, BUSYWAIT}, 32'd0);
        check("reset_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("reset_mem_write", {31'b0, MEM_WRITE}, 32'd0);
        check("reset_readdata", {24'b0, READDATA}, 32'd0);
        check("reset_state", {30'b0, DEBUG_STATE}, 32'd0);

        // Read miss right after reset must request block 1.
        READ = 1'b1; ADDRESS = 8'h05;
        #1;
        check("miss_busywait", {31'b0, BUSYWAIT}, 32'd1);
        @(posedge CLK); #1;
        check("fetch_mem_read", {31'b0, MEM_READ}, 32'd1);
        check("fetch_mem_address", {26'b0, MEM_ADDRESS}, 32'h01);
        check("fetch_no_mem_write", {31'b0, MEM_WRITE}, 32'd0);
        // Let it finish: remaining lat+1 fetch posedges then a hit cycle.
        for (int i = 0; i < 20 && BUSYWAIT !== 1'b0; i++) begin
            @(posedge CLK); #1;
        end
        check("first_fill_rdata", {24'b0, READDATA}, 32'hBB);
        @(posedge CLK); #1;
        READ = 1'b0;
        // Table continues from an empty cache, so re-start the DUT and model.
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 8; i++) begin
            exp_st = model_access(vecs[i].wr, vecs[i].addr);
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, st, rd);
            check($sformatf("vec%0d_stall", i), st, vecs[i].exp_stall);
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), {24'b0, rd}, {24'b0, vecs[i].exp_rdata});
            else ref_bytes[vecs[i].addr] = vecs[i].wdata;
        end
        check("wb_block1_in_mem", mem_words[1], 32'hDD5A_BBAA);
        check("wb_block16_byte0", {24'b0, mem_words[16][7:0]}, 32'h77);

        // ---------------- idle cycles leave everything untouched ----------------
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("idle_quiet", {29'b0, MEM_READ, MEM_WRITE, BUSYWAIT}, 32'd0);
        end
        @(posedge CLK); #1;
        run_checked("idle_reread", 1'b0, 8'h26, 8'h00);

        // ---------------- reset in the middle of a fetch ----------------
        lat = 20;
        READ = 1'b1; ADDRESS = 8'h60;
        repeat (3) @(posedge CLK);
        #1;
        check("midfetch_mem_read", {31'b0, MEM_READ}, 32'd1);
        check("midfetch_state", {30'b0, DEBUG_STATE}, 32'd2);
        check("midfetch_address", {26'b0, MEM_ADDRESS}, 32'h18);
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("abort_mem_read", {31'b0, MEM_READ}, 32'd0);
        check("abort_state", {30'b0, DEBUG_STATE}, 32'd0);
        check("abort_busywait", {31'b0, BUSYWAIT}, 32'd1);
        RESET = 1'b0; READ = 1'b0;
        lat = 3;
        model_reset();
        @(posedge CLK); #1;
        run_checked("after_reset_miss", 1'b0, 8'h26, 8'h00);

        // ---------------- random traffic ----------------
        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(0, 3);
            run_checked("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
Direct-mapped, write-back, write-allocate data cache. It sits between the cpu data-memory port (READ/WRITE/ADDRESS/WRITE_DATA/READ_DATA/DBUSYWAIT) and a block-wide data memory. It serves 8-bit byte accesses from 8 blocks of 4 bytes each. It stalls the cpu through BUSYWAIT during misses and write-backs.

Parameters:
none. Geometry is fixed: 8 blocks × 4 bytes, 8-bit byte address, 32-bit memory block.

Ports:
CLK  input  1  clock, all state updates on posedge
RESET  input  1  synchronous, active-high reset
READ  input  1  cpu byte read request, held stable while BUSYWAIT=1
WRITE  input  1  cpu byte write request, held stable while BUSYWAIT=1
ADDRESS  input  8  cpu byte address: tag=[7:5], index=[4:2], offset=[1:0]
WRITEDATA  input  8  cpu store data
READDATA  output  8  load data to cpu
BUSYWAIT  output  1  stall to cpu (drives DBUSYWAIT)
MEM_READ  output  1  block read request to memory
MEM_WRITE  output  1  block write request to memory
MEM_ADDRESS  output  6  block address {tag,index}
MEM_WRITEDATA  output  32  block to memory
MEM_READDATA  input  32  block from memory, valid in the cycle MEM_BUSYWAIT=0 with MEM_READ=1
MEM_BUSYWAIT  input  1  memory busy; a request completes at the posedge where it is 0

Behaviour:
- Storage per block: data[31:0], tag[2:0], valid, dirty.
- Byte offset k maps to data[8k+7:8k].
- hit = valid[index] & (tag[index]==ADDRESS[7:5]).
- FSM states: IDLE, WRITEBACK, FETCH.
- RESET at posedge:
  - state←IDLE; all valid←0, dirty←0.
  - MEM_READ=MEM_WRITE=0.
  - BUSYWAIT=(READ|WRITE) evaluated as a miss.
  - READDATA=0 while no hit.
  - A reset mid-WRITEBACK/FETCH aborts the transfer; dirty data is discarded.
- IDLE:
  - BUSYWAIT=(READ|WRITE)&!hit, combinational. Hits complete with zero stall cycles.
  - Read hit: READDATA=selected byte, combinational.
  - Write hit: at posedge, byte←WRITEDATA, dirty←1.
  - Miss with dirty victim → WRITEBACK at next posedge.
  - Miss with clean/invalid victim → FETCH at next posedge.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=block data, BUSYWAIT=1.
  - At posedge with MEM_BUSYWAIT=0 → FETCH, dirty←0. Otherwise hold.
- FETCH:
  - MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2], BUSYWAIT=1.
  - At posedge with MEM_BUSYWAIT=0: data←MEM_READDATA, tag←ADDRESS[7:5], valid←1, dirty←0, → IDLE.
  - The access then hits in IDLE next cycle (one extra cycle after fill).
- Outside WRITEBACK/FETCH: MEM_READ=MEM_WRITE=0, MEM_ADDRESS/MEM_WRITEDATA=0.
- MEM_READ and MEM_WRITE are never both 1.
- READ and WRITE both 1: WRITE takes priority; READDATA is don't-care.
- No request (READ=WRITE=0) in IDLE: no state change, BUSYWAIT=0.
- Requests that change while BUSYWAIT=1 are a protocol violation. The cache uses the current ADDRESS at each decision.
- Outputs are purely synchronous/combinational from state. No # delays are required for correctness.

Test Plan:
1. RESET then READ ADDRESS=0x05 → BUSYWAIT=1, FETCH with MEM_ADDRESS=0x01. Memory returns 0xDDCCBBAA after 3 busy cycles → next cycle hit, READDATA=0xBB, BUSYWAIT=0.
2. WRITE 0x5A to 0x06 (block present) → no stall, BUSYWAIT=0. Following READ 0x06 → READDATA=0x5A immediately. dirty[1]=1.
3. READ 0x26 (same index 1, tag 1) after case 2 → WRITEBACK with MEM_WRITE=1, MEM_ADDRESS=0x01, MEM_WRITEDATA=0xDD5ABBAA. Then FETCH with MEM_ADDRESS=0x09, then hit.
4. WRITE miss to 0x40 on clean/invalid block → FETCH only (no MEM_WRITE). Block is filled, then 0x40 byte is written with dirty=1. BUSYWAIT drops one cycle after fill.
5. RESET asserted during FETCH with MEM_BUSYWAIT=1 → next posedge: MEM_READ=0, state IDLE, prior hit address now misses (valid cleared).
6. READ=WRITE=0 for 10 cycles in IDLE → MEM_READ=MEM_WRITE=0, BUSYWAIT=0, contents unchanged (re-read of 0x06 still returns 0x5A).
